// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with start/stop sequencing and boundary-aligned ratio changes
module clk_div_ctrl #(
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2;
  logic [1:0] state, nstate;
  logic [DIV_W-1:0] cnt, ncnt, ndiv, div_pend, cfg_clamp;
  logic [DIV_W:0] half;
  logic wrap, accept, nbusy;
  always_comb begin
    cfg_clamp = cfg_div < DIV_W'(2) ? DIV_W'(2) : cfg_div;
    accept = cfg_valid && cfg_ready;
    wrap = state != IDLE && cnt == cur_div - DIV_W'(1);
    nstate = state == IDLE ? (run ? RUN : IDLE) :
             state == RUN  ? (wrap && !run ? IDLE : accept ? PEND : RUN) :
                             (wrap ? (run ? RUN : IDLE) : PEND);
    ncnt = (state == IDLE || wrap) ? '0 : cnt + DIV_W'(1);
    // a stop-wrap in RUN that also accepts a ratio applies it on entering IDLE
    ndiv = state == IDLE ? (accept ? cfg_clamp : cur_div) :
           state == PEND ? (wrap ? div_pend : cur_div) :
                           (wrap && !run && accept ? cfg_clamp : cur_div);
    half = ({1'b0, ndiv} + (DIV_W+1)'(1)) >> 1;
    nbusy = nstate != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cur_div <= DIV_W'(DEFAULT_DIV);
      div_pend <= '0;
      clk_div <= 1'b0;
      tick <= 1'b0;
      busy <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      cur_div <= ndiv;
      if (state == RUN && accept) div_pend <= cfg_clamp;
      clk_div <= nbusy && {1'b0, ncnt} < half;
      tick <= nbusy && ncnt == '0;
      busy <= nbusy;
      cfg_ready <= nstate != PEND;
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, cfg_valid = 1'b0;
  logic [15:0] cfg_div = '0;
  logic cfg_ready, clk_div, tick, busy;
  logic [15:0] cur_div;
  int n_cmp = 0, n_bad = 0;

  clk_div_ctrl #(.DIV_W(16), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .clk_div(clk_div), .tick(tick), .busy(busy), .cur_div(cur_div)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (clk_div !== 1'b0) begin n_bad++; $display("FAIL reset_clk_div got=%b exp=0", clk_div); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    n_cmp++; if (cur_div !== 16'd2) begin n_bad++; $display("FAIL reset_cur_div got=%0d exp=2", cur_div); end
  endtask

  task automatic test_div2();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (clk_div !== (i % 2 == 0)) begin n_bad++; $display("FAIL div2_clk i=%0d got=%b exp=%b", i, clk_div, i % 2 == 0); end
      n_cmp++; if (tick !== (i % 2 == 0)) begin n_bad++; $display("FAIL div2_tick i=%0d got=%b exp=%b", i, tick, i % 2 == 0); end
      n_cmp++; if (busy !== 1'b1 || cur_div !== 16'd2) begin n_bad++; $display("FAIL div2_busy_div i=%0d busy=%b cur_div=%0d exp 1/2", i, busy, cur_div); end
    end
  endtask

  task automatic test_cfg_idle();
    do_reset();
    cfg_valid = 1'b1; cfg_div = 16'd5;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if (cur_div !== 16'd5 || busy !== 1'b0 || clk_div !== 1'b0) begin n_bad++; $display("FAIL idle_cfg cur_div=%0d busy=%b clk_div=%b exp 5/0/0", cur_div, busy, clk_div); end
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (clk_div !== (i % 5 < 3)) begin n_bad++; $display("FAIL div5_clk i=%0d got=%b exp=%b", i, clk_div, i % 5 < 3); end
      n_cmp++; if (tick !== (i % 5 == 0)) begin n_bad++; $display("FAIL div5_tick i=%0d got=%b exp=%b", i, tick, i % 5 == 0); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL div5_ready i=%0d got=%b exp=1", i, cfg_ready); end
    end
  endtask

  task automatic test_reconfig();
    logic [3:0] exp_clk;
    logic [3:0] exp_rdy;
    do_reset();
    run = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd4;
    exp_clk = 4'b0011;
    exp_rdy = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      cfg_valid = (i == 1 || i == 2);
      cfg_div = (i == 2) ? 16'd3 : 16'd6;
      n_cmp++; if (clk_div !== exp_clk[i]) begin n_bad++; $display("FAIL reconf_old_clk i=%0d got=%b exp=%b", i, clk_div, exp_clk[i]); end
      n_cmp++; if (cfg_ready !== exp_rdy[i]) begin n_bad++; $display("FAIL reconf_ready i=%0d got=%b exp=%b", i, cfg_ready, exp_rdy[i]); end
      n_cmp++; if (cur_div !== 16'd4) begin n_bad++; $display("FAIL reconf_old_div i=%0d got=%0d exp=4", i, cur_div); end
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp++; if (clk_div !== (i % 6 < 3)) begin n_bad++; $display("FAIL reconf_new_clk i=%0d got=%b exp=%b", i, clk_div, i % 6 < 3); end
      n_cmp++; if (tick !== (i % 6 == 0)) begin n_bad++; $display("FAIL reconf_new_tick i=%0d got=%b exp=%b", i, tick, i % 6 == 0); end
      n_cmp++; if (cur_div !== 16'd6 || cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reconf_new_div i=%0d cur_div=%0d ready=%b exp 6/1", i, cur_div, cfg_ready); end
    end
  endtask

  task automatic test_clamp();
    for (int d = 0; d < 2; d++) begin
      do_reset();
      run = 1'b1; cfg_valid = 1'b1; cfg_div = 16'(d);
      for (int i = 0; i < 4; i++) begin
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (cur_div !== 16'd2) begin n_bad++; $display("FAIL clamp_div d=%0d i=%0d got=%0d exp=2", d, i, cur_div); end
        n_cmp++; if (clk_div !== (i % 2 == 0) || tick !== (i % 2 == 0)) begin n_bad++; $display("FAIL clamp_pattern d=%0d i=%0d clk=%b tick=%b exp=%b", d, i, clk_div, tick, i % 2 == 0); end
      end
    end
  endtask

  task automatic test_stop();
    int ticks;
    do_reset();
    run = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd7;
    for (int i = 0; i < 7; i++) begin
      step();
      cfg_valid = 1'b0;
      if (i == 2) run = 1'b0;
      n_cmp++; if (clk_div !== (i < 4) || busy !== 1'b1) begin n_bad++; $display("FAIL stop_period i=%0d clk=%b busy=%b exp %b/1", i, clk_div, busy, i < 4); end
    end
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick) ticks++;
      n_cmp++; if (clk_div !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stop_idle i=%0d clk=%b busy=%b exp 0/0", i, clk_div, busy); end
    end
    n_cmp++; if (ticks !== 0) begin n_bad++; $display("FAIL stop_ticks got=%0d exp=0", ticks); end
    do_reset();
    run = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd7;
    for (int i = 0; i < 15; i++) begin
      step();
      cfg_valid = 1'b0;
      if (i == 2) run = 1'b0;
      if (i == 4) run = 1'b1;
      n_cmp++; if (clk_div !== (i % 7 < 4) || tick !== (i % 7 == 0) || busy !== 1'b1) begin n_bad++; $display("FAIL rerun i=%0d clk=%b tick=%b busy=%b exp %b/%b/1", i, clk_div, tick, busy, i % 7 < 4, i % 7 == 0); end
    end
  endtask

  task automatic test_rst_pend();
    do_reset();
    run = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd4;
    step();
    cfg_div = 16'd9;
    step();
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rstpend_ready got=%b exp=0", cfg_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (clk_div !== 1'b0 || tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || cur_div !== 16'd2) begin n_bad++; $display("FAIL rstpend_state clk=%b tick=%b busy=%b ready=%b div=%0d exp 0/0/0/1/2", clk_div, tick, busy, cfg_ready, cur_div); end
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++; if (clk_div !== (i % 2 == 0) || cur_div !== 16'd2) begin n_bad++; $display("FAIL rstpend_after i=%0d clk=%b div=%0d exp %b/2", i, clk_div, cur_div, i % 2 == 0); end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_cfg_idle();
    test_reconfig();
    test_clamp();
    test_stop();
    test_rst_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time programmable clock-divider controller for the 50 MHz system clock. It sequences start and stop of a divided clock. It accepts new divide ratios through a valid/ready handshake and applies them only at period boundaries, so no period is ever truncated. Outputs are a near-50% duty divided clock (`clk_div`) and a one-cycle `tick` clock-enable for downstream logic in the same clock domain.

Parameters:
DIV_W, 16, width of divide-ratio fields
DEFAULT_DIV, 2, ratio loaded at reset (2 gives the plain divide-by-2 behaviour)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
run  input  1  level: 1 = generate divided clock, 0 = stop at next period boundary
cfg_valid  input  1  new ratio offered
cfg_div  input  DIV_W  requested divide ratio N
cfg_ready  output  1  controller can accept a ratio
clk_div  output  1  divided clock, registered
tick  output  1  one-cycle pulse coincident with each clk_div rising edge
busy  output  1  1 while state != IDLE
cur_div  output  DIV_W  ratio currently in effect

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high. All outputs are registered.
- Reset (sampled `rst`=1 at a rising edge):
  - state=IDLE, cnt=0, cur_div=DEFAULT_DIV, div_pend=0.
  - clk_div=0, tick=0, busy=0, cfg_ready=1.
  - `rst` has priority over every other input. A mid-run or pending reconfig is discarded.
- Ratio clamp: an accepted cfg_div < 2 is stored as 2. The maximum is 2^DIV_W-1.
- Period shape for ratio N:
  - cnt runs 0..N-1, then wraps to 0.
  - clk_div=1 while cnt < ceil(N/2), else 0.
  - tick=1 exactly when cnt==0 in RUN or PEND.
- States: IDLE, RUN, PEND.
  - IDLE:
    - clk_div=0, tick=0.
    - On run=1: next edge goes to RUN with cnt=0, clk_div=1, tick=1 (1-cycle latency from run sampled).
    - A cfg accepted in IDLE updates cur_div at the same edge. If run=1 at that same edge, the first period already uses the new ratio.
  - RUN:
    - cnt increments each cycle and wraps at N-1.
    - cfg_ready=1. On cfg_valid&&cfg_ready: div_pend<=clamp(cfg_div), go to PEND, cfg_ready<=0.
    - An accept on the wrap edge does not apply at that wrap; it applies at the following wrap.
  - PEND:
    - cfg_ready=0. The current period completes with the old cur_div.
    - At the wrap edge (cnt==N-1): cur_div<=div_pend, cnt<=0, cfg_ready<=1.
    - Next state is RUN if run=1, else IDLE.
- Stop:
  - run=0 in RUN or PEND does not stop output immediately. The controller finishes the current period and enters IDLE at the wrap edge.
  - Entering IDLE at the wrap gives clk_div=0 and tick=0. A pending ratio is applied at that same edge.
  - If run returns to 1 before the wrap, operation continues with no gap.
- cfg_valid held while cfg_ready=0 is ignored. The offering side must hold cfg_valid and cfg_div until it sees cfg_ready=1 at an edge.
- busy=1 in RUN and PEND. busy is 0 in the cycle after the stop wrap.
- cur_div always reflects the ratio governing the current period.

Test Plan:
1. Reset, run=1, no cfg -> clk_div 1,0,1,0…; tick every 2nd cycle; cur_div=2; first clk_div=1 one cycle after run sampled.
2. In IDLE, cfg_div=5 accepted, then run=1 -> clk_div pattern 1,1,1,0,0 repeating; tick period 5; cfg_ready stays 1.
3. Running N=4, cfg_div=6 accepted at cnt=1:
   - cfg_ready=0 for the remainder of the period.
   - The period completes 1,1,0,0.
   - Next period is 1,1,1,0,0,0 and cur_div=6 at that wrap.
   - A second cfg_valid during PEND is ignored.
4. cfg_div=0 and cfg_div=1 accepted -> cur_div=2; output identical to scenario 1.
5. N=7 running, run dropped at cnt=2:
   - Period completes (cnt reaches 6), then IDLE.
   - clk_div=0 and busy=0 afterwards; 0 extra ticks after the last period.
   - run re-raised at cnt=4 instead -> uninterrupted pattern.
6. rst asserted one cycle during PEND (N=4 -> 9 pending) -> next edge: all outputs at reset values, cur_div=2, pending 9 lost; after rst released with run=1, divide-by-2 pattern.
